// File: rtl/cc_pkg.sv
// Shared types and helpers for the cc_seq_engine digit calculator.
package cc_pkg;

    typedef enum logic [1:0] {
        OPT_SMOOTH = 2'd0,
        OPT_NORM   = 2'd1,
        OPT_REV    = 2'd2,
        OPT_CPL    = 2'd3
    } opt_e;

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        CALC,
        OUT
    } state_e;

    // Wrap-around difference of two digits: a - b, lifted by m when negative.
    function automatic int mod_sub(input int a, input int b, input int m);
        int d;
        d = a - b;
        if (d < 0) d = d + m;
        return d;
    endfunction

endpackage

// File: rtl/cc_sort_pass.sv
// One odd/even transposition stage: parity 0 orders pairs (0,1),(2,3)..., parity 1 orders (1,2),(3,4)...
module cc_sort_pass #(
    parameter int N_CH = 4,
    parameter int DW   = 4
) (
    input  logic                 parity,
    input  logic [N_CH*DW-1:0]   lanes_in,
    output logic [N_CH*DW-1:0]   lanes_out
);

    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    always_comb begin
        lanes_out = lanes_in;
        for (int j = 0; j < N_CH - 1; j++) begin
            if ((j[0] == parity) && (lanes_in[DW*j +: DW] > lanes_in[DW*(j+1) +: DW])) begin
                lanes_out[DW*j     +: DW] = lanes_in[DW*(j+1) +: DW];
                lanes_out[DW*(j+1) +: DW] = lanes_in[DW*j     +: DW];
            end
        end
    end

endmodule

// File: rtl/cc_seq_engine.sv
// Multi-cycle digit sorter/calculator with valid/ready on both sides.
// Optional CC_RANGE_CHK_EN: clamps out-of-range input lanes and reports in_err.
module cc_seq_engine
    import cc_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int DW   = 4,
    parameter int MOD  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           opt,
    input  logic [N_CH*DW-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_CH*DW-1:0]   out_data
`ifdef CC_RANGE_CHK_EN
    ,
    output logic                 in_err
`endif
);

    localparam int SW = DW + $clog2(N_CH);
    localparam int CW = $clog2(N_CH) + 1;

    typedef logic [DW-1:0] lane_t;

    function automatic lane_t lane_of(input logic [N_CH*DW-1:0] v, input int i);
        return v[DW*i +: DW];
    endfunction

    state_e              state;
    opt_e                opt_q;
    logic [CW-1:0]       pass_cnt;
    logic [N_CH*DW-1:0]  lanes_q;
    logic [N_CH*DW-1:0]  load_flat;
    logic [N_CH*DW-1:0]  pass_flat;
    logic [N_CH*DW-1:0]  calc_flat;
    logic                accept;

    logic [SW-1:0]       sum;
    lane_t               avg;
    lane_t               max_v;
    lane_t               cv;
    int                  max_idx;

    assign accept = in_valid && in_ready;

`ifdef CC_RANGE_CHK_EN
    logic err_q;
    logic load_err;

    always_comb begin
        load_flat = in_data;
        load_err  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(lane_of(in_data, i)) >= MOD) begin
                load_flat[DW*i +: DW] = lane_t'(MOD - 1);
                load_err              = 1'b1;
            end
        end
    end
`else
    assign load_flat = in_data;
`endif

    cc_sort_pass #(.N_CH(N_CH), .DW(DW)) u_pass (
        .parity    (pass_cnt[0]),
        .lanes_in  (lanes_q),
        .lanes_out (pass_flat)
    );

    // NOTE: the lane array carries no reset; it is always loaded on accept before anything reads it.
    always_ff @(posedge clk) begin
        if (accept)
            lanes_q <= load_flat;
        else if (state == SORT)
            lanes_q <= pass_flat;
    end

    always_comb begin
        sum     = '0;
        max_v   = lane_of(lanes_q, 0);
        max_idx = 0;
        cv      = '0;
        for (int i = 0; i < N_CH; i++)
            sum = sum + SW'(lane_of(lanes_q, i));
        avg = lane_t'(sum / SW'(N_CH));
        // '>=' lets a later equal lane take over, so ties go to the highest index.
        for (int i = 1; i < N_CH; i++) begin
            if (lane_of(lanes_q, i) >= max_v) begin
                max_v   = lane_of(lanes_q, i);
                max_idx = i;
            end
        end

        calc_flat = lanes_q;
        case (opt_q)
            OPT_SMOOTH: calc_flat[DW*(N_CH-1) +: DW] = avg;
            OPT_NORM: begin
                for (int i = 0; i < N_CH; i++)
                    calc_flat[DW*i +: DW] = lane_t'(mod_sub(int'(lane_of(lanes_q, i)),
                                                            int'(lane_of(lanes_q, 0)), MOD));
            end
            OPT_REV: begin
                for (int i = 0; i < N_CH; i++)
                    calc_flat[DW*i +: DW] = lane_t'(mod_sub(int'(lane_of(lanes_q, N_CH-1-i)),
                                                            int'(lane_of(lanes_q, N_CH-1)), MOD));
            end
            OPT_CPL: begin
                for (int i = 0; i < N_CH; i++) begin
                    cv = (i == max_idx) ? avg : lane_of(lanes_q, i);
                    calc_flat[DW*i +: DW] = (cv == '0) ? '0 : lane_t'(MOD - int'(cv));
                end
            end
            default: calc_flat = lanes_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            opt_q     <= OPT_SMOOTH;
            pass_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef CC_RANGE_CHK_EN
            err_q     <= 1'b0;
            in_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opt_q    <= opt_e'(opt);
                        pass_cnt <= '0;
                        in_ready <= 1'b0;
`ifdef CC_RANGE_CHK_EN
                        err_q    <= load_err;
`endif
                        state    <= (opt_e'(opt) == OPT_SMOOTH || opt_e'(opt) == OPT_NORM) ? SORT : CALC;
                    end
                end
                SORT: begin
                    if (pass_cnt == CW'(N_CH - 1))
                        state <= CALC;
                    else
                        pass_cnt <= pass_cnt + CW'(1);
                end
                CALC: begin
                    out_data  <= calc_flat;
                    out_valid <= 1'b1;
`ifdef CC_RANGE_CHK_EN
                    in_err    <= err_q;
`endif
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_seq_engine.sv
// Scoreboard bench for cc_seq_engine: directed digit cases plus randomized vectors against a queue-sort model.
module tb_cc_seq_engine;

    localparam int N_CH = 4;
    localparam int DW   = 4;
    localparam int MOD  = 10;
    localparam int W    = N_CH * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    opt;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
`ifdef CC_RANGE_CHK_EN
    logic          in_err;
`endif

    always #5 clk = ~clk;

    cc_seq_engine #(.N_CH(N_CH), .DW(DW), .MOD(MOD)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opt       (opt),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef CC_RANGE_CHK_EN
        ,
        .in_err    (in_err)
`endif
    );

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    // Reference model: plain integers, queue sort, direct reading of the mode rules.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] din, output exp_t e);
        int x[$];
        int y[N_CH];
        int v, sum, avg, mx, idx;
        e.err = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            v = int'(din[DW*i +: DW]);
`ifdef CC_RANGE_CHK_EN
            if (v >= MOD) begin
                v     = MOD - 1;
                e.err = 1'b1;
            end
`endif
            x.push_back(v);
        end
        sum = 0;
        for (int i = 0; i < N_CH; i++) sum += x[i];
        avg = sum / N_CH;
        mx  = -1;
        idx = 0;
        case (o)
            2'd0: begin
                x.sort();
                x[N_CH-1] = avg;
                for (int i = 0; i < N_CH; i++) y[i] = x[i];
            end
            2'd1: begin
                x.sort();
                for (int i = 0; i < N_CH; i++) y[i] = (x[i] - x[0] + MOD) % MOD;
            end
            2'd2: begin
                for (int i = 0; i < N_CH; i++) y[i] = (x[N_CH-1-i] - x[N_CH-1] + MOD) % MOD;
            end
            default: begin
                for (int i = 0; i < N_CH; i++)
                    if (x[i] >= mx) begin
                        mx  = x[i];
                        idx = i;
                    end
                x[idx] = avg;
                for (int i = 0; i < N_CH; i++) y[i] = (x[i] == 0) ? 0 : MOD - x[i];
            end
        endcase
        e.data = '0;
        for (int i = 0; i < N_CH; i++) e.data[DW*i +: DW] = DW'(y[i]);
    endfunction

    // Monitor: a handshake is committed at the next rising edge when both valid and ready are high.
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got %0h, required no output", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL sb_data: got %0h, required %0h", out_data, mon_e.data);
                end
`ifdef CC_RANGE_CHK_EN
                n_cmp++;
                if (in_err !== mon_e.err) begin
                    n_fail++;
                    $display("FAIL sb_err: got %0b, required %0b", in_err, mon_e.err);
                end
`endif
            end
        end
    end

    task automatic send(input logic [1:0] o, input logic [W-1:0] d);
        exp_t e;
        int   t;
        @(negedge clk);
        opt      = o;
        in_data  = d;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0, required 1");
            in_valid = 1'b0;
            return;
        end
        model(o, d, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input int req_edges);
        int edges;
        edges = 0;
        while (!out_valid && edges < 50) begin
            @(posedge clk);
            edges++;
            #1;
        end
        check(name, edges, req_edges);
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_dir(input string name, input logic [1:0] o, input logic [W-1:0] d,
                           input logic [W-1:0] req);
        send(o, d);
        wait_out({name, "_lat"}, (o < 2) ? N_CH + 1 : 1);
        check({name, "_data"}, out_data, req);
        drain();
    endtask

    initial begin
        int seen;
        int ro;
        logic [W-1:0] rd;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opt       = 2'd0;
        in_data   = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
`ifdef CC_RANGE_CHK_EN
        check("rst_in_err", in_err, 0);
`endif
        rst = 1'b0;

        // opt0 with backpressure and an ignored second request.
        send(2'd0, pack4(3, 7, 1, 9));
        wait_out("opt0_lat", N_CH + 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                in_valid = 1'b1;
                opt      = 2'd2;
                in_data  = pack4(5, 5, 5, 5);
            end
            #1;
            check("bp_data", out_data, pack4(1, 3, 7, 5));
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        seen = 0;
        repeat (N_CH + 3) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("bp_second_ignored", seen, 0);
        check("bp_idle_ready", in_ready, 1);

        run_dir("opt1", 2'd1, pack4(3, 7, 1, 9), pack4(0, 2, 6, 8));
        run_dir("opt2", 2'd2, pack4(3, 7, 1, 9), pack4(0, 2, 8, 4));
        run_dir("opt3", 2'd3, pack4(3, 7, 1, 9), pack4(7, 3, 9, 5));
        run_dir("opt3_tie", 2'd3, pack4(9, 2, 9, 0), pack4(1, 8, 5, 0));

        // Reset during the second sort pass.
        send(2'd0, pack4(3, 7, 1, 9));
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        run_dir("after_rst", 2'd0, pack4(8, 2, 5, 4), pack4(2, 4, 5, 4));

`ifdef CC_RANGE_CHK_EN
        run_dir("clamp", 2'd1, pack4(12, 3, 3, 3), pack4(0, 0, 0, 6));
`endif

        for (int k = 0; k < 40; k++) begin
            ro = $urandom_range(0, 3);
            rd = '0;
            for (int i = 0; i < N_CH; i++) begin
`ifdef CC_RANGE_CHK_EN
                rd[DW*i +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
`else
                rd[DW*i +: DW] = DW'($urandom_range(0, MOD - 1));
`endif
            end
            send(2'(ro), rd);
            wait_out("rand_lat", (ro < 2) ? N_CH + 1 : 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drain();
        end

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
